// File: rtl/rc4_pkg.sv
// Shared RC4 types and helpers: KSA state encoding, S-box geometry and key byte extraction.
// Used by the key-scheduling block and the later PRGA/decrypt stage.
package rc4_pkg;

  localparam int S_DEPTH           = 256;
  localparam int KEY_BYTES_DEFAULT = 3;
  localparam int KEY_W_MAX         = 256;

  typedef enum logic [3:0] {
    IDLE,
    RD_I,
    WT_I,
    RD_J,
    WT_J,
    WR_I,
    WR_J,
    NEXT,
    DONE
  } ksa_state_t;

  // Byte idx of an nbytes-long key held right-aligned in key; byte 0 is the most significant.
  function automatic logic [7:0] key_byte(input logic [KEY_W_MAX-1:0] key,
                                          input int nbytes,
                                          input logic [7:0] idx);
    int sh;
    sh = (nbytes - 1 - int'(idx)) * 8;
    if (sh < 0) sh = 0;
    return 8'(key >> sh);
  endfunction

endpackage

// File: rtl/rc4_key_byte_sel.sv
// Combinational big-endian key byte select; indices at or beyond KEY_BYTES return zero.
module rc4_key_byte_sel
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = KEY_BYTES_DEFAULT,
  parameter int KEY_W     = KEY_BYTES * 8
) (
  input  logic [KEY_W-1:0] key,
  input  logic [7:0]       key_idx,
  output logic [7:0]       key_out
);

  logic [KEY_W_MAX-1:0] key_ext;
  logic [7:0]           byte_table [KEY_BYTES];

  assign key_ext = KEY_W_MAX'(key);

  genvar gi;
  generate
    for (gi = 0; gi < KEY_BYTES; gi++) begin : g_byte
      assign byte_table[gi] = key_byte(key_ext, KEY_BYTES, 8'(gi));
    end
  endgenerate

  always_comb begin
    key_out = '0;
    for (int k = 0; k < KEY_BYTES; k++) begin
      if (key_idx == 8'(k)) key_out = byte_table[k];
    end
  end

endmodule

// File: rtl/ksa_swap.sv
// RC4 key-scheduling pass: walks i over S, accumulates j and swaps S[i]/S[j] through a
// single-port synchronous RAM with one-edge read latency (7 cycles per index).
module ksa_swap
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = KEY_BYTES_DEFAULT,
  parameter int KEY_W     = KEY_BYTES * 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [KEY_W-1:0] secret_key,
  input  logic [7:0]       s_q,
  output logic [7:0]       s_address,
  output logic [7:0]       s_data,
  output logic             s_wren,
  output logic             done
);

  ksa_state_t state;
  logic [7:0] i;
  logic [7:0] j;
  logic [7:0] key_idx;
  logic [7:0] si;
  logic [7:0] sj;
  logic [7:0] kbyte;
  logic [7:0] j_new;

  rc4_key_byte_sel #(
    .KEY_BYTES(KEY_BYTES),
    .KEY_W    (KEY_W)
  ) u_key_sel (
    .key    (secret_key),
    .key_idx(key_idx),
    .key_out(kbyte)
  );

  // s_q carries S[i] while in WT_I; the sum wraps naturally in 8 bits.
  assign j_new = j + s_q + kbyte;

  assign s_wren = (state == WR_I) || (state == WR_J);
  assign done   = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      i         <= '0;
      j         <= '0;
      key_idx   <= '0;
      si        <= '0;
      sj        <= '0;
      s_address <= '0;
      s_data    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= RD_I;
            s_address <= '0;
          end
        end
        RD_I: state <= WT_I;
        WT_I: begin
          si        <= s_q;
          j         <= j_new;
          s_address <= j_new;
          state     <= RD_J;
        end
        RD_J: state <= WT_J;
        WT_J: begin
          sj        <= s_q;
          s_address <= i;
          s_data    <= s_q;
          state     <= WR_I;
        end
        WR_I: begin
          // When i==j, si==sj, so the second write repeats the first harmlessly.
          s_address <= j;
          s_data    <= si;
          state     <= WR_J;
        end
        WR_J: state <= NEXT;
        NEXT: begin
          if (i == 8'(S_DEPTH - 1)) begin
            state <= DONE;
          end else begin
            i         <= i + 8'd1;
            key_idx   <= (key_idx == 8'(KEY_BYTES - 1)) ? 8'd0 : key_idx + 8'd1;
            s_address <= i + 8'd1;
            state     <= RD_I;
          end
        end
        DONE:    state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ksa_swap.sv
// Directed bench for ksa_swap: behavioural 256x8 RAM, golden software KSA, write log checks.
module tb_ksa_swap;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [23:0] secret_key = 24'h0;
  logic [7:0]  s_q;
  logic [7:0]  s_address;
  logic [7:0]  s_data;
  logic        s_wren;
  logic        done;

  logic [7:0]  mem  [256];
  logic [7:0]  gold [256];
  logic [15:0] wlog [$];
  int          wr_cnt = 0;
  int          n_pass = 0;
  int          n_total = 0;

  always #5 clk = ~clk;

  ksa_swap #(.KEY_BYTES(3), .KEY_W(24)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .secret_key(secret_key),
    .s_q       (s_q),
    .s_address (s_address),
    .s_data    (s_data),
    .s_wren    (s_wren),
    .done      (done)
  );

  // Single-port RAM, read-first, one-edge read latency.
  always @(posedge clk) begin
    if (s_wren) mem[s_address] <= s_data;
    s_q <= mem[s_address];
  end

  // Write monitor: values seen at negedge are what the RAM samples at the next posedge.
  always @(negedge clk) begin
    if (s_wren) begin
      wr_cnt <= wr_cnt + 1;
      wlog.push_back({s_address, s_data});
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic init_ram();
    for (int k = 0; k < 256; k++) mem[k] = 8'(k);
  endtask

  task automatic golden(input logic [23:0] key);
    int jj;
    logic [7:0] t;
    logic [7:0] kb;
    jj = 0;
    for (int k = 0; k < 256; k++) gold[k] = 8'(k);
    for (int k = 0; k < 256; k++) begin
      kb = 8'(key >> (8 * (2 - (k % 3))));
      jj = (jj + int'(gold[k]) + int'(kb)) % 256;
      t = gold[k];
      gold[k] = gold[jj];
      gold[jj] = t;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    wlog.delete();
    wr_cnt = 0;
  endtask

  // Waits for done with a cycle budget; returns cycles counted from the call.
  task automatic wait_done(input int budget, input bit pulse, output int cycles);
    cycles = 0;
    while (cycles < budget) begin
      @(posedge clk);
      #1;
      cycles++;
      if (pulse) start = 1'b0;
      if (done) break;
    end
  endtask

  task automatic check_final(input string tag);
    int mism;
    mism = 0;
    for (int k = 0; k < 256; k++) if (mem[k] !== gold[k]) mism++;
    check(tag, mism, 0);
  endtask

  initial begin
    int cyc;
    int quiet_bad;
    int done_low;
    int wr_before;

    init_ram();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_addr", s_address, 0);
    check("rst_data", s_data, 0);
    check("rst_wren", s_wren, 0);
    check("rst_done", done, 0);
    reset = 1'b0;

    // start held low: no RAM activity
    quiet_bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (s_wren || done || s_address != 0) quiet_bad++;
    end
    check("idle_quiet", quiet_bad, 0);
    check("idle_writes", wr_cnt, 0);

    // Key 0x00033C with a one-cycle start pulse; latency and write count.
    secret_key = 24'h00033C;
    golden(secret_key);
    @(posedge clk);
    #1;
    start = 1'b1;
    wait_done(3000, 1'b1, cyc);
    check("latency", cyc, 1793);
    check("wr_count", wr_cnt, 512);
    check("w0", wlog[0], 16'h0000);
    check("w1", wlog[1], 16'h0000);
    check("w2_s1", wlog[2], 16'h0104);
    check("w3_s4", wlog[3], 16'h0401);
    check("w4_s2", wlog[4], 16'h0242);
    check("w5_s42", wlog[5], 16'h4202);
    check_final("final_033c");

    done_low = 0;
    wr_before = wr_cnt;
    repeat (100) begin
      @(negedge clk);
      if (!done) done_low++;
    end
    check("done_hold", done_low, 0);
    check("no_writes_after_done", wr_cnt, wr_before);

    // Key 0xFFFFFF, start held: j wraps.
    do_reset();
    init_ram();
    secret_key = 24'hFFFFFF;
    golden(secret_key);
    start = 1'b1;
    wait_done(3000, 1'b0, cyc);
    start = 1'b0;
    check("ff_done", done, 1);
    check("ff_w0", wlog[0], 16'h00FF);
    check("ff_w1", wlog[1], 16'hFF00);
    check("ff_w2", wlog[2], 16'h0100);
    check("ff_w3", wlog[3], 16'hFF01);
    check_final("final_ffffff");

    // Key 0x000000: i==j double write at address 0.
    do_reset();
    init_ram();
    secret_key = 24'h000000;
    golden(secret_key);
    start = 1'b1;
    wait_done(3000, 1'b1, cyc);
    check("z_done", done, 1);
    check("z_w0", wlog[0], 16'h0000);
    check("z_w1", wlog[1], 16'h0000);
    check_final("final_000000");

    // Reset during WR_I of i=37 (75th write cycle), then re-init and rerun.
    do_reset();
    init_ram();
    secret_key = 24'h00033C;
    golden(secret_key);
    start = 1'b1;
    cyc = 0;
    while (wr_cnt < 75 && cyc < 3000) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check("mid_reached", wr_cnt, 75);
    check("mid_wr_i_addr", {24'h0, wlog[74][15:8]}, 37);
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check("mid_rst_wren", s_wren, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_addr", s_address, 0);
    reset = 1'b0;
    wlog.delete();
    wr_cnt = 0;
    init_ram();
    start = 1'b1;
    wait_done(3000, 1'b1, cyc);
    check("rerun_latency", cyc, 1793);
    check("rerun_wr_count", wr_cnt, 512);
    check_final("final_rerun");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ksa_swap.md
Name: ksa_swap

Overview:
- Runs the RC4 key-scheduling pass over S memory after the identity-init block has asserted done.
- For i = 0..255: j = j + S[i] + key[i mod KEY_BYTES], then swap S[i] and S[j].
- Reads S through the same single-port synchronous RAM port the init block writes. Top-level muxes RAM address/data/wren between blocks by phase.
- Asserts done when the S array is fully scrambled, ready for the PRGA/decrypt stage.

Parameters:
- KEY_BYTES, 3: secret key length in bytes.
- KEY_W, 24: key width, KEY_BYTES*8.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high
- start  input  1  level; sampled only in IDLE; tied to init-block done at top
- secret_key  input  KEY_W  key; byte 0 = secret_key[KEY_W-1 -: 8], big-endian; held stable while running
- s_q  input  8  RAM read data
- s_address  output  8  RAM address, registered
- s_data  output  8  RAM write data, registered
- s_wren  output  1  RAM write enable, decoded from state
- done  output  1  high in DONE, decoded from state

Behaviour:
- RAM timing: address/data/wren sampled at clock edge E. s_q is valid after E and is captured by this block at E+1.
- Reset (any cycle, including mid-iteration):
  - state=IDLE; i=0, j=0, key_idx=0, si=0, sj=0.
  - s_address=0, s_data=0, s_wren=0, done=0.
  - A partially swapped S is not repaired; the top re-runs init.
- Start: IDLE with start=1 -> RD_I, s_address<=0.
  - start is ignored after leaving IDLE; deassertion mid-run has no effect.
- Per-iteration states (7 cycles):
  - RD_I: s_address holds i; RAM latches it.
  - WT_I: at exit edge, si<=s_q, j<=j+s_q+keybyte(key_idx) mod 256, s_address<=new j.
  - RD_J: RAM latches j.
  - WT_J: at exit edge, sj<=s_q, s_address<=i, s_data<=s_q.
  - WR_I: s_wren=1; writes S[i]=sj. At exit, s_address<=j, s_data<=si.
  - WR_J: s_wren=1; writes S[j]=si.
  - NEXT:
    - i==255 -> DONE.
    - Otherwise i<=i+1, key_idx<=(key_idx==KEY_BYTES-1)?0:key_idx+1, s_address<=i+1, -> RD_I.
- DONE: terminal, done=1, s_wren=0; left only by reset.
- Arithmetic: all 8-bit, wrap modulo 256 with no carry kept. i wraps only conceptually; it stops at 255.
- i==j: both writes hit the same address with the same value (si==sj); this is legal and needs no special case.
- key_idx is a counter, not a modulo operator.
- Latency: start accepted at edge T0. done rises 1 + 256*7 = 1793 cycles later.
- s_wren is high only in WR_I/WR_J: exactly 512 write cycles per run.

Decomposition:
- rc4_pkg holds:
  - the ksa_state_t enum (IDLE, RD_I, WT_I, RD_J, WT_J, WR_I, WR_J, NEXT, DONE);
  - the S_DEPTH=256 and KEY_BYTES_DEFAULT=3 constants;
  - a function key_byte(key, idx) returning the big-endian byte.
- The PRGA block reuses this package.
- One natural sub-module, rc4_key_byte_sel: combinational KEY_W->8 byte select by key_idx. It is shared later with PRGA.
- The FSM and datapath stay in ksa_swap.

Test Plan:
- Bench drives a behavioural 256x8 RAM with the stated 1-edge read latency, preloaded identity.
- Key 0x00033C, run to done:
  - i=0: j=0, S[0] stays 0.
  - i=1: j=4 -> S[1]=4, S[4]=1.
  - i=2: j=0x42 -> S[2]=0x42, S[0x42]=2.
  - Final S matches the golden software KSA.
- Key 0xFFFFFF (j wrap):
  - i=0: j=0xFF -> S[0]=0xFF, S[0xFF]=0.
  - i=1: j=0xFF -> S[1]=0, S[0xFF]=1.
- Key 0x000000 (i==j): i=0 issues two writes to address 0 with data 0. No corruption; final S matches golden.
- Timing: start rises at cycle 10 -> done rises at cycle 10+1793.
  - Count s_wren-high cycles = 512.
  - done stays high 100 further cycles; no further writes.
- Reset during the WR_I of i=37:
  - Next cycle: IDLE, s_wren=0, done=0.
  - Re-init plus restart yields S identical to an uninterrupted run.
- start held 0 for 50 cycles after reset: no RAM activity, s_wren=0, done=0. start pulsed for 1 cycle: full run still completes.
